seg_scan_driver: RTL and testbench

Parametrised N-digit multiplexed seven-segment scanner. It replaces the separate 1 kHz divider and fixed 4-digit hex driver with one block clocked directly from the system clock. Added features: a built-in prescaler, per-digit enable, leading-zero blanking, PWM brightness, frame-coherent input snapshot with freeze, anti-ghost dead cycle, and selectable pin polarity. It sits in the board top and drives the seg/an pins from the Chip-8 debug word.

---
 rtl/seg_scan_driver_pkg.sv | 38 +++
 rtl/seg_scan_driver_if.sv | 26 ++
 rtl/seg_scan_driver_tick_prescaler.sv | 32 +++
 rtl/seg_scan_driver.sv | 138 +++++++++++++
 tb/tb_seg_scan_driver.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/seg_scan_driver_pkg.sv
// Shared seven-segment helpers: hex glyph decode, dp bit index, width helper.
// Pure constants/functions; no timing or flow control.
package seg_pkg;

  localparam int SEG_DP = 7;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Glyph bits are {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display request/pin bundle between a debug source and the scanner.
// No handshake: inputs are level-sampled, outputs are registered pins.
interface seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4,
  parameter int PWM_BITS   = 3
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    blank_lz;
  logic                    freeze;
  logic [PWM_BITS-1:0]     brightness;
  logic [7:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_tick;

  modport master (
    output digits, dp, digit_en, blank_lz, freeze, brightness,
    input  seg, an, frame_tick
  );

  modport slave (
    input  digits, dp, digit_en, blank_lz, freeze, brightness,
    output seg, an, frame_tick
  );
endinterface

// File: rtl/seg_scan_driver_tick_prescaler.sv
// Free-running modulo-DIV counter; tick is combinational on the last count.
// Latency: tick asserts in the same cycle cnt==DIV-1; no backpressure.
module tick_prescaler
  import seg_pkg::*;
#(
  parameter  int DIV   = 4,
  localparam int CNT_W = (clog2(DIV) < 1) ? 1 : clog2(DIV)
) (
  input  logic             clk,
  input  logic             res_n,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seg_scan_driver.sv
// N-digit multiplexed 7-seg scanner with LZ blanking, PWM, frame snapshot/freeze.
// Latency: 1 clk from scan state to pins; no backpressure (free-running scan).
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_HZ     = 100000000,
  parameter int SCAN_HZ    = 1000,
  parameter int PWM_BITS   = 3,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              res_n,
  seg_scan_driver_if.slave  bus
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_OFF  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  if (DIV < 2) begin : g_bad_div
    $error("seg_scan_driver: CLK_HZ/SCAN_HZ must be >= 2");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seg_scan_driver: NUM_DIGITS must be 1..8");
  end

  logic [CNT_W-1:0]        cnt;
  logic                    slot_end;
  logic                    wrap;

  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [PWM_BITS-1:0]     pwm_cnt_q, pwm_cnt_d;
  logic [4*NUM_DIGITS-1:0] snap_dig_q, snap_dig_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]   snap_en_q, snap_en_d;
  logic                    frame_tick_q, frame_tick_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              seg_q, seg_d;

  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    zero_run;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_en, cur_lz, lit;
  logic [NUM_DIGITS-1:0]   an_onehot, an_raw;
  logic [7:0]              seg_raw;

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .res_n (res_n),
    .cnt   (cnt),
    .tick  (slot_end)
  );

  always_comb begin
    wrap         = slot_end && (idx_q == IDX_LAST);
    idx_d        = idx_q;
    pwm_cnt_d    = pwm_cnt_q + PWM_BITS'(1);
    snap_dig_d   = snap_dig_q;
    snap_dp_d    = snap_dp_q;
    snap_en_d    = snap_en_q;
    frame_tick_d = wrap;

    if (slot_end) idx_d = wrap ? '0 : idx_q + IDX_W'(1);

    // Capture only at the frame boundary so a frame is always self-consistent.
    if (wrap && !bus.freeze) begin
      snap_dig_d = bus.digits;
      snap_dp_d  = bus.dp;
      snap_en_d  = bus.digit_en;
    end

    // A digit is a leading zero if it and every digit above it are zero;
    // digit 0 always shows so a zero value still reads "0".
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (snap_dig_q[4*i +: 4] == 4'h0);
      if (i > 0) lz_blank[i] = bus.blank_lz & zero_run;
    end

    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_en    = 1'b0;
    cur_lz    = 1'b0;
    an_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib      = snap_dig_q[4*i +: 4];
        cur_dp       = snap_dp_q[i];
        cur_en       = snap_en_q[i];
        cur_lz       = lz_blank[i];
        an_onehot[i] = 1'b1;
      end
    end

    // First cycle of each slot stays dark so the previous digit cannot ghost.
    lit = cur_en & ~cur_lz & (pwm_cnt_q <= bus.brightness) & (cnt != '0);

    an_raw          = lit ? an_onehot : '0;
    seg_raw         = '0;
    seg_raw[6:0]    = lit ? hex7(cur_nib) : 7'h00;
    seg_raw[SEG_DP] = lit & cur_dp;

    an_d  = (ACTIVE_LOW != 0) ? ~an_raw  : an_raw;
    seg_d = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      idx_q        <= '0;
      pwm_cnt_q    <= '0;
      snap_dig_q   <= '0;
      snap_dp_q    <= '0;
      snap_en_q    <= '0;
      frame_tick_q <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
    end else begin
      idx_q        <= idx_d;
      pwm_cnt_q    <= pwm_cnt_d;
      snap_dig_q   <= snap_dig_d;
      snap_dp_q    <= snap_dp_d;
      snap_en_q    <= snap_en_d;
      frame_tick_q <= frame_tick_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: DIV=4, 4 digits, both pin polarities.
module tb_seg_scan_driver;

  logic clk;
  logic res_n;
  int   checks;
  int   failures;
  int   e;

  seg_scan_driver_if #(.NUM_DIGITS(4), .PWM_BITS(3)) bus ();
  seg_scan_driver_if #(.NUM_DIGITS(4), .PWM_BITS(3)) bus2 ();

  seg_scan_driver #(
    .NUM_DIGITS(4), .CLK_HZ(16), .SCAN_HZ(4), .PWM_BITS(3), .ACTIVE_LOW(1)
  ) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );

  seg_scan_driver #(
    .NUM_DIGITS(4), .CLK_HZ(16), .SCAN_HZ(4), .PWM_BITS(3), .ACTIVE_LOW(0)
  ) dut_hi (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    e++;
    #1;
  endtask

  // Runs until the first frame_tick after a reset release; pins must stay dark.
  task automatic wait_first_frame(input string tag);
    int n;
    int lit_cnt;
    n = 0;
    lit_cnt = 0;
    while (n < 40) begin
      step();
      n++;
      if (bus.an !== 4'hF) lit_cnt++;
      if (bus.frame_tick === 1'b1) break;
    end
    chk({tag, "_tick_latency"}, n, 16);
    chk({tag, "_zero_snapshot_dark"}, lit_cnt, 0);
  endtask

  // Checks one whole frame (brightness 7); vis marks digits expected lit.
  task automatic check_frame(input string tag, input logic [3:0] vis,
                             input logic [3:0][7:0] seg_exp, input logic [15:0] mid_digits);
    for (int k = 0; k < 16; k++) begin
      int d;
      logic lit;
      logic [3:0] an_e;
      logic [7:0] seg_e;
      step();
      d = k / 4;
      lit = (k % 4) != 0;
      an_e  = (lit && vis[d]) ? ~(4'b0001 << d) : 4'hF;
      seg_e = (lit && vis[d]) ? seg_exp[d] : 8'hFF;
      chk($sformatf("%s_an_k%0d", tag, k), bus.an, an_e);
      chk($sformatf("%s_seg_k%0d", tag, k), bus.seg, seg_e);
      chk($sformatf("%s_tick_k%0d", tag, k), bus.frame_tick, (k == 15) ? 1 : 0);
      chk($sformatf("%s_hi_an_k%0d", tag, k), bus2.an, lit ? (4'b0001 << d) : 4'h0);
      chk($sformatf("%s_hi_seg_k%0d", tag, k), bus2.seg, lit ? 8'h7F : 8'h00);
      if (k == 7) bus.digits = mid_digits;
    end
  endtask

  task automatic count_lit(input string tag, input logic [2:0] br, input int exp);
    int n;
    n = 0;
    bus.brightness = br;
    for (int k = 0; k < 64; k++) begin
      step();
      if (bus.an !== 4'hF) n++;
    end
    chk(tag, n, exp);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    e        = 0;
    res_n    = 1'b1;
    bus.digits     = 16'h12AF;
    bus.dp         = 4'b0100;
    bus.digit_en   = 4'hF;
    bus.blank_lz   = 1'b0;
    bus.freeze     = 1'b0;
    bus.brightness = 3'd7;
    bus2.digits     = 16'h8888;
    bus2.dp         = 4'b0000;
    bus2.digit_en   = 4'hF;
    bus2.blank_lz   = 1'b0;
    bus2.freeze     = 1'b0;
    bus2.brightness = 3'd7;

    #3 res_n = 1'b0;
    #1;
    chk("rst_an", bus.an, 4'hF);
    chk("rst_seg", bus.seg, 8'hFF);
    chk("rst_tick", bus.frame_tick, 0);
    chk("rst_hi_an", bus2.an, 4'h0);
    chk("rst_hi_seg", bus2.seg, 8'h00);

    repeat (2) @(posedge clk);
    @(negedge clk);
    res_n = 1'b1;
    e = 0;
    wait_first_frame("boot");

    // blank_lz is live but 12AF has no leading zero; 0030 arrives mid-frame.
    bus.blank_lz = 1'b1;
    check_frame("f12af", 4'b1111, {8'hF9, 8'h24, 8'h88, 8'h8E}, 16'h0030);
    check_frame("lz0030", 4'b0011, {8'hFF, 8'hFF, 8'hB0, 8'hC0}, 16'hFFFF);
    bus.blank_lz = 1'b0;

    count_lit("pwm_br0", 3'd0, 0);
    count_lit("pwm_br1", 3'd1, 8);
    count_lit("pwm_br5", 3'd5, 32);
    chk("frame_align_after_pwm", e % 16, 0);

    bus.brightness = 3'd7;
    bus.freeze = 1'b1;
    bus.digits = 16'h1234;
    check_frame("frz1", 4'b1111, {8'h8E, 8'h0E, 8'h8E, 8'h8E}, 16'h5678);
    check_frame("frz2", 4'b1111, {8'h8E, 8'h0E, 8'h8E, 8'h8E}, 16'h9ABC);
    check_frame("frz3", 4'b1111, {8'h8E, 8'h0E, 8'h8E, 8'h8E}, 16'h4321);
    bus.freeze = 1'b0;
    check_frame("unfrz_old", 4'b1111, {8'h8E, 8'h0E, 8'h8E, 8'h8E}, 16'h4321);
    check_frame("unfrz_new", 4'b1111, {8'h99, 8'h30, 8'hA4, 8'hF9}, 16'h4321);

    step();
    step();
    chk("pre_midrst_an", bus.an, 4'b1110);
    chk("pre_midrst_seg", bus.seg, 8'hF9);
    res_n = 1'b0;
    #1;
    chk("midrst_an", bus.an, 4'hF);
    chk("midrst_seg", bus.seg, 8'hFF);
    chk("midrst_tick", bus.frame_tick, 0);
    chk("midrst_hi_an", bus2.an, 4'h0);
    chk("midrst_hi_seg", bus2.seg, 8'h00);
    @(negedge clk);
    res_n = 1'b1;
    e = 0;
    wait_first_frame("rerun");
    check_frame("rerun_4321", 4'b1111, {8'h99, 8'h30, 8'hA4, 8'hF9}, 16'h4321);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
